// File: rtl/exc_commit_pkg.sv
// Shared exception definitions: ExcCode values, wb_exc bit positions, vector layout.
// Also used by the CP0 register file.
`timescale 1ns/1ps
package exc_commit_pkg;

  localparam int EXC_W        = 10;
  localparam int EXC_IF_ADEL  = 0;
  localparam int EXC_IF_TLBL  = 1;
  localparam int EXC_RI       = 2;
  localparam int EXC_CPU      = 3;
  localparam int EXC_OV       = 4;
  localparam int EXC_TR       = 5;
  localparam int EXC_SYS      = 6;
  localparam int EXC_BP       = 7;
  localparam int EXC_DATA_ADE = 8;
  localparam int EXC_DATA_TLB = 9;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_MOD  = 5'd1;
  localparam logic [4:0] CODE_TLBL = 5'd2;
  localparam logic [4:0] CODE_TLBS = 5'd3;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_CPU  = 5'd11;
  localparam logic [4:0] CODE_OV   = 5'd12;
  localparam logic [4:0] CODE_TR   = 5'd13;

  localparam int STATUS_EXL = 1;
  localparam int STATUS_BEV = 22;
  localparam int CAUSE_IV   = 23;

  localparam logic [31:0] BEV_BASE    = 32'hBFC0_0200;
  localparam logic [11:0] OFS_REFILL  = 12'h000;
  localparam logic [11:0] OFS_GENERAL = 12'h180;
  localparam logic [11:0] OFS_INT_IV  = 12'h200;

  typedef enum logic {ST_IDLE = 1'b0, ST_REDIR = 1'b1} state_t;

  function automatic logic [31:0] vec_base(input logic bev, input logic [31:0] ebase);
    return bev ? BEV_BASE : {ebase[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/exc_commit_prio.sv
// Combinational exception arbiter: picks the winning cause and its ExcCode.
// valid covers interrupts too; is_fetch marks instruction-side faults (bad address = PC).
`timescale 1ns/1ps
module exc_prio
  import exc_commit_pkg::*;
(
  input  logic [EXC_W-1:0] wb_exc,
  input  logic             wb_store,
  input  logic             wb_mod,
  input  logic             int_sig,
  output logic             valid,
  output logic [4:0]       code,
  output logic             is_fetch
);

  always_comb begin
    valid    = 1'b1;
    code     = CODE_INT;
    is_fetch = 1'b0;
    if (int_sig) begin
      code = CODE_INT;
    end else if (wb_exc[EXC_IF_ADEL]) begin
      code     = CODE_ADEL;
      is_fetch = 1'b1;
    end else if (wb_exc[EXC_IF_TLBL]) begin
      code     = CODE_TLBL;
      is_fetch = 1'b1;
    end else if (wb_exc[EXC_RI])       code = CODE_RI;
    else if (wb_exc[EXC_CPU])          code = CODE_CPU;
    else if (wb_exc[EXC_OV])           code = CODE_OV;
    else if (wb_exc[EXC_TR])           code = CODE_TR;
    else if (wb_exc[EXC_SYS])          code = CODE_SYS;
    else if (wb_exc[EXC_BP])           code = CODE_BP;
    else if (wb_exc[EXC_DATA_ADE])     code = wb_store ? CODE_ADES : CODE_ADEL;
    else if (wb_exc[EXC_DATA_TLB])     code = wb_mod ? CODE_MOD : (wb_store ? CODE_TLBS : CODE_TLBL);
    else                               valid = 1'b0;
  end

endmodule

// File: rtl/exc_commit.sv
// Exception/ERET commit: strobes CP0, flushes the pipe, then holds a redirect until the data bus drains.
// EXC_TLB_REFILL_VEC_EN: TLB refill misses with EXL=0 vector to offset 0x000.
`timescale 1ns/1ps
module exc_commit
  import exc_commit_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [31:0]      wb_pc,
  input  logic [31:0]      wb_mem_vaddr,
  input  logic             wb_bd,
  input  logic             wb_eret,
  input  logic             wb_refill,
  input  logic [EXC_W-1:0] wb_exc,
  input  logic             wb_store,
  input  logic             wb_mod,
  input  logic             int_sig,
  input  logic [31:0]      status,
  input  logic [31:0]      cause,
  input  logic [31:0]      epc,
  input  logic [31:0]      ebase,
  output logic             commit_exc,
  output logic             commit_eret,
  output logic             commit_bd,
  output logic [4:0]       commit_code,
  output logic [31:0]      commit_epc,
  output logic [31:0]      commit_bvaddr,
  output logic             flush,
  input  logic             mem_idle,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [31:0]      redirect_pc
);

  state_t      state_q, state_d;
  logic        prio_valid, prio_fetch;
  logic [4:0]  prio_code;
  logic        accept, is_eret, take;
  logic [11:0] vec_ofs;
  logic [31:0] exc_target, redirect_q;
  logic        unused_bits;

  exc_prio u_prio (
    .wb_exc   (wb_exc),
    .wb_store (wb_store),
    .wb_mod   (wb_mod),
    .int_sig  (int_sig),
    .valid    (prio_valid),
    .code     (prio_code),
    .is_fetch (prio_fetch)
  );

  assign wb_ready       = (state_q == ST_IDLE);
  assign accept         = wb_valid && wb_ready;
  assign is_eret        = !prio_valid && wb_eret && (wb_exc == '0);
  assign take           = prio_valid || is_eret;
  assign redirect_valid = (state_q == ST_REDIR) && mem_idle;

  always_comb begin
    vec_ofs = OFS_GENERAL;
    if (int_sig && cause[CAUSE_IV]) begin
      vec_ofs = OFS_INT_IV;
`ifdef EXC_TLB_REFILL_VEC_EN
    end else if (!int_sig && (prio_code == CODE_TLBL || prio_code == CODE_TLBS) &&
                 wb_refill && !status[STATUS_EXL]) begin
      vec_ofs = OFS_REFILL;
`else
    end else begin
      vec_ofs = OFS_GENERAL;
`endif
    end
  end

  assign exc_target  = vec_base(status[STATUS_BEV], ebase) + {20'h0, vec_ofs};
  assign unused_bits = ^{wb_refill, status, cause, ebase[11:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && take) state_d = ST_REDIR;
      ST_REDIR: if (redirect_valid && redirect_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ERET target is EPC as seen one cycle after accept, so it is captured while commit_eret is high.
  assign redirect_pc = commit_eret ? epc : redirect_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      commit_exc    <= 1'b0;
      commit_eret   <= 1'b0;
      flush         <= 1'b0;
      commit_code   <= CODE_INT;
      commit_bd     <= 1'b0;
      commit_epc    <= '0;
      commit_bvaddr <= '0;
      redirect_q    <= '0;
    end else begin
      state_q     <= state_d;
      commit_exc  <= accept && take;
      commit_eret <= accept && is_eret;
      flush       <= accept && take;
      if (commit_eret) redirect_q <= epc;
      if (accept && take) begin
        commit_code   <= prio_code;
        commit_bd     <= wb_bd;
        commit_epc    <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
        commit_bvaddr <= prio_fetch ? wb_pc : wb_mem_vaddr;
        redirect_q    <= exc_target;
      end
    end
  end

endmodule
